// File: rtl/data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// data_bus_arbiter: round-robin arbiter letting two masters share one
// in-order data slave; responses are steered back through an ID FIFO.
// Revision: 1.0
// ============================================================================
module data_bus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 2
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                m0_req,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic                m0_we,
    input  logic [DATA_W/8-1:0] m0_be,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_req,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic                m1_we,
    input  logic [DATA_W/8-1:0] m1_be,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic                s_req,
    input  logic                s_gnt,
    input  logic                s_rvalid,
    output logic [ADDR_W-1:0]   s_addr,
    output logic                s_we,
    output logic [DATA_W/8-1:0] s_be,
    output logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W-1:0]   s_rdata,

    output logic                err
);

    localparam int               PTR_W    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int               CNT_W    = $clog2(MAX_OUTST + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTST);

    logic             last_win;
    logic             lock;
    logic             lock_id;
    logic             sel;
    logic             sel_req;
    logic             full;
    logic             hs;
    logic             pop;
    logic             head_id;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             id_fifo [MAX_OUTST];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // A stalled request pins the selection so the slave sees stable fields.
    always_comb begin
        if (lock) begin
            sel = lock_id;
        end else if (m0_req && m1_req) begin
            sel = ~last_win;
        end else begin
            sel = m1_req;
        end
    end

    assign sel_req = sel ? m1_req : m0_req;
    assign full    = (count == CNT_FULL);

    assign s_req   = sel_req & ~full;
    assign s_addr  = sel ? m1_addr  : m0_addr;
    assign s_we    = sel ? m1_we    : m0_we;
    assign s_be    = sel ? m1_be    : m0_be;
    assign s_wdata = sel ? m1_wdata : m0_wdata;

    assign hs      = s_req & s_gnt;
    assign m0_gnt  = hs & ~sel;
    assign m1_gnt  = hs & sel;

    assign pop       = s_rvalid & (count != '0);
    assign head_id   = id_fifo[rd_ptr];
    assign m0_rvalid = pop & ~head_id;
    assign m1_rvalid = pop & head_id;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_win <= 1'b1;
            lock     <= 1'b0;
            lock_id  <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            err      <= 1'b0;
        end else begin
            if (hs) begin
                last_win <= sel;
                lock     <= 1'b0;
                wr_ptr   <= ptr_inc(wr_ptr);
            end else if (s_req) begin
                lock     <= 1'b1;
                lock_id  <= sel;
            end

            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end

            // A response with nothing outstanding is a slave protocol violation.
            if (s_rvalid && (count == '0)) begin
                err <= 1'b1;
            end

            case ({hs, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (hs) begin
            id_fifo[wr_ptr] <= sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_data_bus_arbiter: vector table plus directed sequences, with a slave
// model and a response scoreboard.
// Revision: 1.0
// ============================================================================
module tb_data_bus_arbiter;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic        m0_we = 1'b0, m1_we = 1'b1;
    logic [3:0]  m0_be = 4'hF, m1_be = 4'h3;
    logic [31:0] m0_wdata = 32'h1111_1111, m1_wdata = 32'h2222_2222;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_gnt, s_rvalid, s_we;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;
    logic        err;

    logic        gnt_en = 1'b1;
    logic        spur = 1'b0;
    int          lat = 1;
    int          checks = 0;
    int          errors = 0;

    data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_addr(m0_addr),
        .m0_we(m0_we), .m0_be(m0_be), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_addr(m1_addr),
        .m1_we(m1_we), .m1_be(m1_be), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_addr(s_addr),
        .s_we(s_we), .s_be(s_be), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Slave model: grants whenever enabled, answers in order after lat cycles.
    typedef struct { int due; logic [31:0] data; } rsp_t;
    rsp_t        rq[$];
    int          cyc = 0;
    logic        hs_n = 1'b0;
    logic [31:0] addr_n = '0;
    logic        rv_q = 1'b0;
    logic [31:0] rd_q = '0;

    assign s_gnt    = s_req & gnt_en & rst_n;
    assign s_rvalid = rv_q | spur;
    assign s_rdata  = rd_q;

    always @(negedge clk) begin
        hs_n   = s_req & s_gnt;
        addr_n = s_addr;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq.delete();
            rv_q = 1'b0;
            rd_q = '0;
        end else begin
            if (rv_q) void'(rq.pop_front());
            if (hs_n) rq.push_back('{cyc + lat, memf(addr_n)});
            cyc++;
            rv_q = (rq.size() > 0) && (rq[0].due == cyc);
            rd_q = rv_q ? rq[0].data : 32'h0;
        end
    end

    // Scoreboard: each grant queues the master id and the data its address must return.
    typedef struct { bit id; logic [31:0] data; } sb_t;
    sb_t sb[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_rvalid || m1_rvalid) begin
                checks++;
                if (m0_rvalid && m1_rvalid) begin
                    errors++;
                    $display("FAIL sb_both_rvalid actual=11 expected=one-hot");
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_rvalid actual=%b%b expected=00", m1_rvalid, m0_rvalid);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    if (m1_rvalid !== e.id || (e.id ? m1_rdata : m0_rdata) !== e.data) begin
                        errors++;
                        $display("FAIL sb_resp actual=id%0d/%h expected=id%0d/%h",
                                 m1_rvalid, m1_rvalid ? m1_rdata : m0_rdata, e.id, e.data);
                    end
                end
            end
            if (m0_gnt) sb.push_back('{1'b0, memf(m0_addr)});
            if (m1_gnt) sb.push_back('{1'b1, memf(m1_addr)});
        end
    end

    task automatic drive(input bit r0, input logic [31:0] a0, input bit r1,
                         input logic [31:0] a1, input bit ge, input bit sp);
        @(posedge clk);
        #1;
        m0_req  = r0;
        m0_addr = a0;
        m1_req  = r1;
        m1_addr = a1;
        gnt_en  = ge;
        spur    = sp;
        @(negedge clk);
    endtask

    typedef struct {
        bit r0; bit r1; logic [31:0] a0; logic [31:0] a1; bit ge;
        bit e_sel; bit e_g0; bit e_g1; bit e_sreq; bit e_rv0; bit e_rv1;
    } vec_t;
    vec_t vt[13];

    initial begin
        // r0 r1 a0 a1 gnt_en | sel g0 g1 s_req rv0 rv1
        vt[0]  = '{H, H, 32'h00, 32'h04, H, L, H, L, H, L, L};
        vt[1]  = '{H, H, 32'h00, 32'h04, H, H, L, H, H, H, L};
        vt[2]  = '{H, H, 32'h00, 32'h04, H, L, H, L, H, L, H};
        vt[3]  = '{H, H, 32'h00, 32'h04, H, H, L, H, H, H, L};
        vt[4]  = '{L, L, 32'h00, 32'h04, H, L, L, L, L, L, H};
        vt[5]  = '{H, L, 32'h10, 32'h04, H, L, H, L, H, L, L};
        vt[6]  = '{L, L, 32'h10, 32'h04, H, L, L, L, L, H, L};
        vt[7]  = '{H, L, 32'h20, 32'h24, L, L, L, L, H, L, L};
        vt[8]  = '{H, H, 32'h20, 32'h24, L, L, L, L, H, L, L};
        vt[9]  = '{H, H, 32'h20, 32'h24, L, L, L, L, H, L, L};
        vt[10] = '{H, H, 32'h20, 32'h24, H, L, H, L, H, L, L};
        vt[11] = '{L, H, 32'h20, 32'h24, H, H, L, H, H, H, L};
        vt[12] = '{L, L, 32'h20, 32'h24, H, L, L, L, L, L, H};

        // Reset state
        drive(L, '0, L, '0, H, L);
        drive(L, '0, L, '0, H, L);
        chk("rst_m0_gnt", 32'(m0_gnt), 0);
        chk("rst_m1_gnt", 32'(m1_gnt), 0);
        chk("rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 0);
        chk("rst_err", 32'(err), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Alternating pair, single read of 0xDEADBEEF, stall with lock
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].r0, vt[i].a0, vt[i].r1, vt[i].a1, vt[i].ge, L);
            chk($sformatf("v%0d_m0_gnt", i), 32'(m0_gnt), 32'(vt[i].e_g0));
            chk($sformatf("v%0d_m1_gnt", i), 32'(m1_gnt), 32'(vt[i].e_g1));
            chk($sformatf("v%0d_s_req", i), 32'(s_req), 32'(vt[i].e_sreq));
            chk($sformatf("v%0d_m0_rvalid", i), 32'(m0_rvalid), 32'(vt[i].e_rv0));
            chk($sformatf("v%0d_m1_rvalid", i), 32'(m1_rvalid), 32'(vt[i].e_rv1));
            if (vt[i].e_sreq) begin
                chk($sformatf("v%0d_s_addr", i), s_addr, vt[i].e_sel ? vt[i].a1 : vt[i].a0);
                chk($sformatf("v%0d_s_fields", i), {27'b0, s_we, s_be},
                    vt[i].e_sel ? 32'h13 : 32'h0F);
                chk($sformatf("v%0d_s_wdata", i), s_wdata,
                    vt[i].e_sel ? 32'h2222_2222 : 32'h1111_1111);
            end
        end

        // Outstanding limit with a 3-cycle slave
        lat = 3;
        drive(H, 32'h40, L, 32'h0, H, L);
        chk("fl_c0_gnt", 32'(m0_gnt), 1);
        drive(H, 32'h44, L, 32'h0, H, L);
        chk("fl_c1_gnt", 32'(m0_gnt), 1);
        drive(H, 32'h48, L, 32'h0, H, L);
        chk("fl_c2_s_req", 32'(s_req), 0);
        chk("fl_c2_gnt", 32'(m0_gnt), 0);
        drive(H, 32'h48, L, 32'h0, H, L);
        chk("fl_c3_s_req", 32'(s_req), 0);
        chk("fl_c3_rvalid", 32'(m0_rvalid), 1);
        drive(H, 32'h48, L, 32'h0, H, L);
        chk("fl_c4_gnt", 32'(m0_gnt), 1);
        chk("fl_c4_rvalid", 32'(m0_rvalid), 1);
        drive(L, 32'h0, L, 32'h0, H, L);
        chk("fl_c5_rvalid", 32'(m0_rvalid), 0);
        drive(L, 32'h0, L, 32'h0, H, L);
        drive(L, 32'h0, L, 32'h0, H, L);
        chk("fl_c7_rvalid", 32'(m0_rvalid), 1);
        drive(L, 32'h0, L, 32'h0, H, L);
        chk("fl_sb_drained", sb.size(), 0);

        // Spurious response
        lat = 1;
        chk("sp_err_before", 32'(err), 0);
        drive(L, 32'h0, L, 32'h0, H, H);
        chk("sp_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 0);
        drive(L, 32'h0, L, 32'h0, H, L);
        chk("sp_err_set", 32'(err), 1);
        for (int i = 0; i < 10; i++) begin
            drive(L, 32'h0, L, 32'h0, H, L);
            chk($sformatf("sp_err_hold%0d", i), 32'(err), 1);
        end

        // Reset with two responses outstanding
        lat = 3;
        drive(H, 32'h60, L, 32'h0, H, L);
        chk("rr_c0_gnt", 32'(m0_gnt), 1);
        drive(H, 32'h64, L, 32'h0, H, L);
        chk("rr_c1_gnt", 32'(m0_gnt), 1);
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        sb.delete();
        chk("rr_gnt", {30'b0, m1_gnt, m0_gnt}, 0);
        chk("rr_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 0);
        chk("rr_err", 32'(err), 0);
        drive(L, 32'h0, L, 32'h0, H, L);
        chk("rr_hold_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m0_req  = 1'b1;
        m0_addr = 32'h70;
        m1_req  = 1'b1;
        m1_addr = 32'h74;
        @(negedge clk);
        chk("rr_first_m0_gnt", 32'(m0_gnt), 1);
        chk("rr_first_m1_gnt", 32'(m1_gnt), 0);
        drive(L, 32'h70, H, 32'h74, H, L);
        chk("rr_next_m1_gnt", 32'(m1_gnt), 1);
        for (int i = 0; i < 5; i++) drive(L, 32'h0, L, 32'h0, H, L);
        chk("rr_sb_drained", sb.size(), 0);
        chk("rr_err_after", 32'(err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
